alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: round-robin grant,
// operand capture, one-cycle execute and a held response with backpressure.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for a request; grant computed combinationally
// S_EXEC | operands latched and driving the ALU; result captured at cycle end
// S_RESP | response presented on rsp_*; held until rsp_ready
module alu_arbiter #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic              req1_valid,
   output logic              req0_ready,
   output logic              req1_ready,
   input  logic [WIDTH-1:0]  req0_a,
   input  logic [WIDTH-1:0]  req0_b,
   input  logic [WIDTH-1:0]  req1_a,
   input  logic [WIDTH-1:0]  req1_b,
   input  logic [CTRL_W-1:0] req0_ctrl,
   input  logic [CTRL_W-1:0] req1_ctrl,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   output logic [CTRL_W-1:0] alu_ctrl,
   input  logic [WIDTH-1:0]  alu_result,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [WIDTH-1:0]  rsp_result,
   output logic              rsp_err,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [CTRL_W-1:0] LAST_LEGAL = CTRL_W'(12);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_last_grant;
   logic [WIDTH-1:0]    r_a;
   logic [WIDTH-1:0]    r_b;
   logic [CTRL_W-1:0]   r_ctrl;
   logic                r_id;
   logic                r_rsp_id;
   logic [WIDTH-1:0]    r_rsp_result;
   logic                r_rsp_err;

   logic                w_grant_any;
   logic                w_grant_id;
   logic                w_accept;
   logic                w_illegal;

   // On contention the requester that did not win last time goes next.
   always_comb begin
      w_grant_any = req0_valid | req1_valid;
      w_grant_id  = 1'b0;
      if (req0_valid && req1_valid) begin
         w_grant_id = ~r_last_grant;
      end else if (req1_valid) begin
         w_grant_id = 1'b1;
      end
      w_accept   = rst_n && (r_state == S_IDLE) && w_grant_any;
      req0_ready = w_accept && !w_grant_id;
      req1_ready = w_accept && w_grant_id;
      w_illegal  = (r_ctrl > LAST_LEGAL);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
         S_EXEC:  w_state_nxt = S_RESP;
         S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a          <= '0;
         r_b          <= '0;
         r_ctrl       <= '0;
         r_id         <= 1'b0;
         r_last_grant <= 1'b1;
      end else if (w_accept) begin
         r_a          <= w_grant_id ? req1_a    : req0_a;
         r_b          <= w_grant_id ? req1_b    : req0_b;
         r_ctrl       <= w_grant_id ? req1_ctrl : req0_ctrl;
         r_id         <= w_grant_id;
         r_last_grant <= w_grant_id;
      end
   end

   // Illegal op codes return zero regardless of what the ALU produced.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_id     <= 1'b0;
         r_rsp_result <= '0;
         r_rsp_err    <= 1'b0;
      end else if (r_state == S_EXEC) begin
         r_rsp_id     <= r_id;
         r_rsp_result <= w_illegal ? '0 : alu_result;
         r_rsp_err    <= w_illegal;
      end
   end

   assign alu_a      = r_a;
   assign alu_b      = r_b;
   assign alu_ctrl   = r_ctrl;
   assign rsp_valid  = (r_state == S_RESP);
   assign rsp_id     = r_rsp_id;
   assign rsp_result = r_rsp_result;
   assign rsp_err    = r_rsp_err;
   assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios then random traffic,
// with a cycle-level reference model and a separate response monitor.
module tb_alu_arbiter;

   localparam int W = 32;
   localparam int C = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [C-1:0] req0_ctrl = '0, req1_ctrl = '0;
   logic [W-1:0] alu_a, alu_b, alu_result;
   logic [C-1:0] alu_ctrl;
   logic         rsp_valid, rsp_id, rsp_err, busy;
   logic         rsp_ready = 1'b1;
   logic [W-1:0] rsp_result;

   alu_arbiter #(.WIDTH(W), .CTRL_W(C)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Shared ALU; codes 13..15 return garbage so the zeroing is observable.
   function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [C-1:0] op);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return a << b[4:0];
         4'd6:    return a >> b[4:0];
         4'd7:    return (a < b) ? 32'd1 : 32'd0;
         4'd8:    return ~a;
         4'd9:    return a + 32'd1;
         4'd10:   return a - 32'd1;
         4'd11:   return ~(a & b);
         4'd12:   return ~(a | b);
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   assign alu_result = alu_fn(alu_a, alu_b, alu_ctrl);

   typedef struct {
      logic         id;
      logic [W-1:0] res;
      logic         err;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;

   // reference model state
   bit           m_free = 1'b1;
   bit           m_last = 1'b1;
   int           m_acc = 0;
   logic [W-1:0] m_alu_a = '0, m_alu_b = '0;
   logic [C-1:0] m_alu_ctrl = '0;
   bit           keep0 = 1'b0, keep1 = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         if (sbq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_unexpected at cycle %0d: got rsp id %0d result %h expected no response",
                     cyc, rsp_id, rsp_result);
         end else begin
            check("rsp_id", {31'd0, rsp_id}, {31'd0, sbq[0].id});
            check("rsp_result", rsp_result, sbq[0].res);
            check("rsp_err", {31'd0, rsp_err}, {31'd0, sbq[0].err});
            if (rsp_ready) void'(sbq.pop_front());
         end
      end
   end

   task automatic cycle(output int acc_id);
      logic         e0, e1, exp_rv, id;
      logic [W-1:0] a, b;
      logic [C-1:0] op;
      exp_t         e;
      @(negedge clk);
      acc_id = -1;
      if (!rst_n) begin
         check("rst_ready0", {31'd0, req0_ready}, 32'd0);
         check("rst_ready1", {31'd0, req1_ready}, 32'd0);
         check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
         check("rst_busy", {31'd0, busy}, 32'd0);
         check("rst_alu_a", alu_a, 32'd0);
         check("rst_alu_b", alu_b, 32'd0);
         check("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
         check("rst_rsp_result", rsp_result, 32'd0);
         check("rst_rsp_id_err", {30'd0, rsp_id, rsp_err}, 32'd0);
         m_free = 1'b1;
         m_last = 1'b1;
         m_alu_a = '0;
         m_alu_b = '0;
         m_alu_ctrl = '0;
         sbq.delete();
      end else begin
         exp_rv = !m_free && (cyc >= m_acc + 2);
         check("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rv});
         check("busy", {31'd0, busy}, {31'd0, !m_free});
         check("alu_a", alu_a, m_alu_a);
         check("alu_b", alu_b, m_alu_b);
         check("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, m_alu_ctrl});
         e0 = 1'b0;
         e1 = 1'b0;
         if (m_free) begin
            e0 = req0_valid && (!req1_valid || m_last);
            e1 = req1_valid && (!req0_valid || !m_last);
         end
         check("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
         check("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
         if (e0 || e1) begin
            id = e1;
            a  = id ? req1_a : req0_a;
            b  = id ? req1_b : req0_b;
            op = id ? req1_ctrl : req0_ctrl;
            e.id  = id;
            e.err = (op > 4'd12);
            e.res = e.err ? 32'd0 : alu_fn(a, b, op);
            sbq.push_back(e);
            m_last = id;
            m_free = 1'b0;
            m_acc = cyc;
            m_alu_a = a;
            m_alu_b = b;
            m_alu_ctrl = op;
            acc_id = id ? 1 : 0;
         end else if (exp_rv && rsp_ready) begin
            m_free = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic new_op(input int r);
      logic [W-1:0] a, b;
      a = ($urandom_range(0, 1) == 0) ? $urandom : W'($urandom_range(0, 40));
      b = ($urandom_range(0, 1) == 0) ? $urandom : W'($urandom_range(0, 40));
      if (r == 0) begin
         req0_a = a; req0_b = b; req0_ctrl = C'($urandom_range(0, 15)); req0_valid = 1'b1;
      end else begin
         req1_a = a; req1_b = b; req1_ctrl = C'($urandom_range(0, 15)); req1_valid = 1'b1;
      end
   endtask

   task automatic after_cycle(input int acc_id);
      if (acc_id == 0) begin
         if (keep0) new_op(0); else req0_valid = 1'b0;
      end else if (acc_id == 1) begin
         if (keep1) new_op(1); else req1_valid = 1'b0;
      end
   endtask

   task automatic run(input int n);
      int id;
      for (int i = 0; i < n; i++) begin
         cycle(id);
         after_cycle(id);
      end
   endtask

   task automatic do_reset();
      int id;
      rst_n = 1'b0;
      cycle(id);
      rst_n = 1'b1;
   endtask

   task automatic set0(input logic [C-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      req0_ctrl = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
   endtask

   task automatic set1(input logic [C-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      req1_ctrl = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
   endtask

   initial begin
      int id;
      @(posedge clk);
      #1;
      do_reset();
      do_reset();

      set0(4'b0000, 32'd10, 32'd3);
      run(5);

      do_reset();
      set0(4'd2, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
      set1(4'd1, 32'd5, 32'd10);
      run(8);

      keep0 = 1'b1;
      keep1 = 1'b1;
      new_op(0);
      new_op(1);
      run(12);
      keep0 = 1'b0;
      keep1 = 1'b0;
      run(6);

      set0(4'd3, 32'h1234_0000, 32'h0000_5678);
      rsp_ready = 1'b0;
      run(8);
      rsp_ready = 1'b1;
      run(2);

      set1(4'b1111, 32'd7, 32'd9);
      run(4);
      set1(4'd4, 32'hFFFF_0000, 32'h00FF_FF00);
      run(4);

      set1(4'd0, 32'd1, 32'd2);
      run(1);
      do_reset();
      set0(4'd0, 32'd100, 32'd1);
      set1(4'd0, 32'd200, 32'd1);
      run(8);

      set1(4'd9, 32'd41, 32'd0);
      rsp_ready = 1'b0;
      run(3);
      do_reset();
      rsp_ready = 1'b1;
      set0(4'd1, 32'd9, 32'd4);
      set1(4'd1, 32'd8, 32'd4);
      run(8);

      for (int i = 0; i < 600; i++) begin
         rsp_ready = ($urandom_range(0, 3) != 0);
         if (!req0_valid && $urandom_range(0, 9) < 4) new_op(0);
         else if (req0_valid && $urandom_range(0, 9) == 0) req0_valid = 1'b0;
         if (!req1_valid && $urandom_range(0, 9) < 4) new_op(1);
         else if (req1_valid && $urandom_range(0, 9) == 0) req1_valid = 1'b0;
         if (i == 300) do_reset();
         cycle(id);
         after_cycle(id);
      end

      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready = 1'b1;
      run(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
